// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: the in-flight slot record,
// the Execute operand-select encoding and the result-ready helper.
package hazard_pkg;

  // Slots carry register addresses at this fixed width; narrower register files zero-extend.
  localparam int HZ_AW = 8;

  typedef struct packed {
    logic             valid;
    logic             regw;
    logic             load;
    logic [HZ_AW-1:0] wa;
    logic [HZ_AW-1:0] ra1;
    logic [HZ_AW-1:0] ra2;
    logic             use1;
    logic             use2;
  } slot_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  function automatic int rdy_slot(input logic load, input int alu_rdy, input int ld_rdy);
    return load ? ld_rdy : alu_rdy;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one in-flight slot against one source operand: hit when the slot
// writes that register, ready when the slot's result exists at position IDX.
module hazard_slot_match
  import hazard_pkg::*;
#(
  parameter int IDX     = 0,
  parameter int ALU_RDY = 1,
  parameter int LD_RDY  = 2,
  parameter int PC_REG  = 15
) (
  input  logic             valid,
  input  logic             regw,
  input  logic             load,
  input  logic [HZ_AW-1:0] wa,
  input  logic [HZ_AW-1:0] src,
  input  logic             use_src,
  output logic             hit,
  output logic             ready
);

  // The PC register is produced by the register bank itself, so it never depends on the pipe.
  assign hit   = valid && regw && use_src && (wa == src) && (src != HZ_AW'(PC_REG));
  assign ready = (IDX >= rdy_slot(load, ALU_RDY, LD_RDY));

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: tracks in-flight writes in STAGES post-decode slots,
// raises load-use stalls and branch flushes, and selects Execute operand sources.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int STAGES    = 3,
  parameter int ALU_RDY   = 1,
  parameter int LD_RDY    = 2,
  parameter int PC_REG    = 15,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = (STAGES <= 3) ? 2 : $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_ra1,
  input  logic [REG_AW-1:0] dec_ra2,
  input  logic              dec_use1,
  input  logic              dec_use2,
  input  logic              dec_regw,
  input  logic              dec_load,
  input  logic [REG_AW-1:0] dec_wa,
  input  logic              br_taken_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [SEL_W-1:0]  fwd_a_e,
  output logic [SEL_W-1:0]  fwd_b_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (STAGES < 2 || LD_RDY < ALU_RDY || LD_RDY >= STAGES || REG_AW > HZ_AW) begin : g_cfg_err
    $error("hazard_scoreboard: illegal STAGES/ALU_RDY/LD_RDY/REG_AW combination");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Mux input order: regfile, oldest (writeback) slot, slot 1, then deeper slots by index.
  function automatic logic [SEL_W-1:0] slot_sel(input int j);
    if (j == STAGES - 1) return (WB_BYPASS != 0) ? SEL_W'(FWD_RF) : SEL_W'(FWD_W);
    if (j == 1) return SEL_W'(FWD_M);
    return SEL_W'(j + 1);
  endfunction

  slot_t            slot_q [STAGES];
  slot_t            slot_d [STAGES];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [HZ_AW-1:0]  dec_src1, dec_src2, dec_dst;
  logic [STAGES-1:0] dhit_a, drdy_a, dhit_b, drdy_b;
  logic [STAGES-1:0] ehit_a, erdy_a, ehit_b, erdy_b;
  logic              load_use;
  logic [SEL_W-1:0]  fwd_a, fwd_b;

  assign dec_src1 = HZ_AW'(dec_ra1);
  assign dec_src2 = HZ_AW'(dec_ra2);
  assign dec_dst  = HZ_AW'(dec_wa);

  // Decode sources are checked one position ahead, since they reach E a cycle later.
  for (genvar i = 0; i < STAGES; i++) begin : g_match
    hazard_slot_match #(.IDX(i + 1), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .PC_REG(PC_REG)) u_dec_a (
      .valid(slot_q[i].valid), .regw(slot_q[i].regw), .load(slot_q[i].load), .wa(slot_q[i].wa),
      .src(dec_src1), .use_src(dec_use1), .hit(dhit_a[i]), .ready(drdy_a[i])
    );
    hazard_slot_match #(.IDX(i + 1), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .PC_REG(PC_REG)) u_dec_b (
      .valid(slot_q[i].valid), .regw(slot_q[i].regw), .load(slot_q[i].load), .wa(slot_q[i].wa),
      .src(dec_src2), .use_src(dec_use2), .hit(dhit_b[i]), .ready(drdy_b[i])
    );
    hazard_slot_match #(.IDX(i), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .PC_REG(PC_REG)) u_exe_a (
      .valid(slot_q[i].valid), .regw(slot_q[i].regw), .load(slot_q[i].load), .wa(slot_q[i].wa),
      .src(slot_q[0].ra1), .use_src(slot_q[0].use1), .hit(ehit_a[i]), .ready(erdy_a[i])
    );
    hazard_slot_match #(.IDX(i), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .PC_REG(PC_REG)) u_exe_b (
      .valid(slot_q[i].valid), .regw(slot_q[i].regw), .load(slot_q[i].load), .wa(slot_q[i].wa),
      .src(slot_q[0].ra2), .use_src(slot_q[0].use2), .hit(ehit_b[i]), .ready(erdy_b[i])
    );
  end

  assign load_use = dec_valid && (|((dhit_a & ~drdy_a) | (dhit_b & ~drdy_b)));

  // A taken branch discards the Decode instruction, so it wins over any stall.
  assign stall_d = rst && load_use && !br_taken_e;
  assign stall_f = stall_d;
  assign flush_d = rst && br_taken_e;
  assign flush_e = rst && (load_use || br_taken_e);

  always_comb begin
    fwd_a = SEL_W'(FWD_RF);
    fwd_b = SEL_W'(FWD_RF);
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (j != 0 && ehit_a[j] && erdy_a[j]) fwd_a = slot_sel(j);
      if (j != 0 && ehit_b[j] && erdy_b[j]) fwd_b = slot_sel(j);
    end
  end

  assign fwd_a_e = (rst && slot_q[0].valid) ? fwd_a : SEL_W'(FWD_RF);
  assign fwd_b_e = (rst && slot_q[0].valid) ? fwd_b : SEL_W'(FWD_RF);

  always_comb begin
    slot_d[0] = '0;
    if (dec_valid && !stall_d && !flush_e) begin
      slot_d[0].valid = 1'b1;
      slot_d[0].regw  = dec_regw;
      slot_d[0].load  = dec_load;
      slot_d[0].wa    = dec_dst;
      slot_d[0].ra1   = dec_src1;
      slot_d[0].ra2   = dec_src2;
      slot_d[0].use1  = dec_use1;
      slot_d[0].use2  = dec_use2;
    end
    for (int i = 1; i < STAGES; i++) slot_d[i] = slot_q[i-1];
  end

  always_comb begin
    stall_cnt_d = stall_d    ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = br_taken_e ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) slot_q[i] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default instance and a deep instance (STAGES=4,
// LD_RDY=3, CNT_W=2, no writeback bypass) share one stimulus stream.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dec_valid, dec_use1, dec_use2, dec_regw, dec_load, br_taken_e;
  logic [3:0] dec_ra1, dec_ra2, dec_wa;

  logic        a_stall_f, a_stall_d, a_flush_d, a_flush_e;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_stall_f, b_stall_d, b_flush_d, b_flush_e;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [1:0]  b_scnt, b_fcnt;

  hazard_scoreboard u_dut_a (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_regw(dec_regw), .dec_load(dec_load),
    .dec_wa(dec_wa), .br_taken_e(br_taken_e), .stall_f(a_stall_f), .stall_d(a_stall_d),
    .flush_d(a_flush_d), .flush_e(a_flush_e), .fwd_a_e(a_fwd_a), .fwd_b_e(a_fwd_b),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  hazard_scoreboard #(.STAGES(4), .LD_RDY(3), .CNT_W(2), .WB_BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_regw(dec_regw), .dec_load(dec_load),
    .dec_wa(dec_wa), .br_taken_e(br_taken_e), .stall_f(b_stall_f), .stall_d(b_stall_d),
    .flush_d(b_flush_d), .flush_e(b_flush_e), .fwd_a_e(b_fwd_a), .fwd_b_e(b_fwd_b),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  // Reference model: every issued instruction remembers the cycle it entered Execute;
  // its distance from Execute is simply (current cycle - that cycle).
  typedef struct {
    bit regw;
    bit load;
    int wa;
    int ra1;
    int ra2;
    bit use1;
    bit use2;
    int issue;
  } rec_t;
  typedef rec_t rq_t[$];

  rq_t q0, q1;
  int  cyc = 0;
  int  sn[2], fn[2];
  bit  exp_stall[2], exp_fe[2];
  int  n_pass = 0, n_total = 0;

  function automatic bit haz(input rec_t r, input int src, input bit use_src);
    return r.regw && use_src && (r.wa == src) && (src != 15);
  endfunction

  function automatic logic [1:0] sel_of(input int j, input int st, input bit byp);
    if (j >= st) return 2'd0;
    if (j == st - 1) return byp ? 2'd0 : 2'd1;
    if (j == 1) return 2'd2;
    return 2'(j + 1);
  endfunction

  function automatic void model(input rq_t q, input int st, input int ld, input bit byp,
                                output bit sr, output logic [1:0] fa, output logic [1:0] fb);
    rec_t e;
    bit   have_e;
    int   ja, jb;
    sr = 1'b0; have_e = 1'b0; ja = st; jb = st;
    e = '{default: 0};
    foreach (q[n]) begin
      int age, rdy;
      age = cyc - q[n].issue;
      rdy = q[n].load ? ld : 1;
      if (age == 0) begin e = q[n]; have_e = 1'b1; end
      if (dec_valid && (age + 1 < rdy) &&
          (haz(q[n], int'(dec_ra1), dec_use1) || haz(q[n], int'(dec_ra2), dec_use2))) sr = 1'b1;
    end
    if (have_e) begin
      foreach (q[n]) begin
        int age, rdy;
        age = cyc - q[n].issue;
        rdy = q[n].load ? ld : 1;
        if (age >= 1 && age >= rdy) begin
          if (haz(q[n], e.ra1, e.use1) && age < ja) ja = age;
          if (haz(q[n], e.ra2, e.use2) && age < jb) jb = age;
        end
      end
    end
    fa = sel_of(ja, st, byp);
    fb = sel_of(jb, st, byp);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_cfg(input int k);
    rq_t        q;
    bit         sr, e_st, e_fd, e_fe;
    logic [1:0] fa, fb;
    int         cmax, es, ef;
    if (k == 0) begin q = q0; model(q, 3, 2, 1'b1, sr, fa, fb); cmax = 65535; end
    else begin q = q1; model(q, 4, 3, 1'b0, sr, fa, fb); cmax = 3; end
    e_st = rst && sr && !br_taken_e;
    e_fd = rst && br_taken_e;
    e_fe = rst && (sr || br_taken_e);
    if (!rst) begin fa = 2'd0; fb = 2'd0; end
    es = (sn[k] > cmax) ? cmax : sn[k];
    ef = (fn[k] > cmax) ? cmax : fn[k];
    exp_stall[k] = e_st;
    exp_fe[k]    = e_fe;
    if (k == 0) begin
      chk("A.stall_f", 32'(a_stall_f), 32'(e_st));
      chk("A.stall_d", 32'(a_stall_d), 32'(e_st));
      chk("A.flush_d", 32'(a_flush_d), 32'(e_fd));
      chk("A.flush_e", 32'(a_flush_e), 32'(e_fe));
      chk("A.fwd_a_e", 32'(a_fwd_a), 32'(fa));
      chk("A.fwd_b_e", 32'(a_fwd_b), 32'(fb));
      chk("A.stall_cnt", 32'(a_scnt), 32'(es));
      chk("A.flush_cnt", 32'(a_fcnt), 32'(ef));
    end else begin
      chk("B.stall_f", 32'(b_stall_f), 32'(e_st));
      chk("B.stall_d", 32'(b_stall_d), 32'(e_st));
      chk("B.flush_d", 32'(b_flush_d), 32'(e_fd));
      chk("B.flush_e", 32'(b_flush_e), 32'(e_fe));
      chk("B.fwd_a_e", 32'(b_fwd_a), 32'(fa));
      chk("B.fwd_b_e", 32'(b_fwd_b), 32'(fb));
      chk("B.stall_cnt", 32'(b_scnt), 32'(es));
      chk("B.flush_cnt", 32'(b_fcnt), 32'(ef));
    end
  endtask

  task automatic advance(input int k);
    rq_t  q;
    rec_t r;
    int   st;
    if (k == 0) begin q = q0; st = 3; end
    else begin q = q1; st = 4; end
    if (!rst) begin
      q.delete();
      sn[k] = 0;
      fn[k] = 0;
    end else begin
      if (exp_stall[k]) sn[k]++;
      if (br_taken_e) fn[k]++;
      if (dec_valid && !exp_fe[k]) begin
        r.regw = dec_regw; r.load = dec_load; r.wa = int'(dec_wa);
        r.ra1 = int'(dec_ra1); r.ra2 = int'(dec_ra2);
        r.use1 = dec_use1; r.use2 = dec_use2; r.issue = cyc + 1;
        q.push_back(r);
      end
    end
    while (q.size() > 0 && (cyc + 1 - q[0].issue) >= st) void'(q.pop_front());
    if (k == 0) q0 = q; else q1 = q;
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) begin
      q0.delete(); q1.delete();
      sn[0] = 0; sn[1] = 0; fn[0] = 0; fn[1] = 0;
    end
    check_cfg(0);
    check_cfg(1);
    @(posedge clk);
    advance(0);
    advance(1);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input bit regw, input bit load, input int wa,
                       input int ra1, input int ra2, input bit u1, input bit u2, input bit br);
    dec_valid = v; dec_regw = regw; dec_load = load; dec_wa = 4'(wa);
    dec_ra1 = 4'(ra1); dec_ra2 = 4'(ra2); dec_use1 = u1; dec_use2 = u2; br_taken_e = br;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  function automatic int rand_reg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 15 : r;
  endfunction

  task automatic rand_inputs();
    drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
          rand_reg(), rand_reg(), rand_reg(), $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
  endtask

  initial begin
    // Reset held with random inputs, then released with an empty Decode.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_inputs(); step(); end
    rst = 1'b1;
    nop(2);

    // ALU to ALU back-to-back, then with one unrelated instruction between.
    drive(1, 1, 0, 3, 1, 2, 1, 1, 0); step();
    drive(1, 1, 0, 4, 3, 1, 1, 1, 0); step();
    nop(3);
    drive(1, 1, 0, 3, 1, 2, 1, 1, 0); step();
    drive(1, 1, 0, 9, 1, 2, 1, 1, 0); step();
    drive(1, 1, 0, 4, 1, 3, 1, 1, 0); step();
    nop(4);

    // Load-use: dependent held in Decode for as long as the deep instance stalls.
    drive(1, 1, 1, 5, 1, 0, 1, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 6, 5, 2, 1, 1, 0); step(); end
    nop(4);

    // Taken branch in the same cycle as a load-use hazard.
    drive(1, 1, 1, 5, 1, 0, 1, 0, 0); step();
    drive(1, 1, 0, 6, 5, 2, 1, 1, 1); step();
    nop(4);

    // PC register and an unused operand never hazard.
    drive(1, 1, 1, 15, 1, 0, 1, 0, 0); step();
    drive(1, 1, 0, 6, 15, 2, 1, 1, 0); step();
    nop(3);
    drive(1, 1, 1, 7, 1, 0, 1, 0, 0); step();
    drive(1, 1, 0, 6, 1, 7, 1, 0, 0); step();
    nop(4);

    // Reset asserted in the middle of a multi-cycle stall.
    drive(1, 1, 1, 5, 1, 0, 1, 0, 0); step();
    drive(1, 1, 0, 6, 5, 2, 1, 1, 0); step();
    rst = 1'b0; step();
    rst = 1'b1;
    nop(3);

    // Enough taken branches to saturate the narrow counter.
    for (int i = 0; i < 5; i++) begin drive(1, 1, 0, 2, 1, 1, 1, 1, 1); step(); end
    nop(2);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 63) != 0);
      step();
    end
    rst = 1'b1;
    nop(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
